// File: rtl/ieeedrv_pkg.sv
// Shared types and helpers for the SD image-channel arbiter.
package ieeedrv_pkg;

  localparam int unsigned TO_W   = 24;
  localparam int unsigned MAX_CH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_FIN
  } arb_state_e;

  // Round-robin pick: first set bit of pend at or after ptr+1, wrapping modulo nch.
  // The caller must only use the result when pend has a bit set below nch.
  function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] pend,
                                         input logic [2:0]        ptr,
                                         input int unsigned       nch);
    logic [2:0] sel;
    logic [2:0] idx;
    logic       found;
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (i < nch) begin
        idx = 3'((32'(ptr) + i + 32'd1) % nch);
        if (!found && pend[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ieeedrv_sd_req.sv
// Per-channel request latch: holds pending flag, direction, LBA and block count.
module ieeedrv_sd_req #(
  parameter int unsigned BLK_W = 6
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic [31:0]      req_lba,
  input  logic [BLK_W-1:0] req_blk_cnt,
  input  logic             mount,
  input  logic             active,
  input  logic             fin_clr,
  output logic             pending,
  output logic             dir_wr,
  output logic [31:0]      lba,
  output logic [BLK_W-1:0] blk_cnt
);

  logic             pending_q, pending_d;
  logic             dir_wr_q, dir_wr_d;
  logic [31:0]      lba_q, lba_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             accept;

  // Capture a strobe only when the channel is idle; a mount cancels a request
  // that has not been granted yet, but never the one being transferred.
  always_comb begin
    pending_d = pending_q;
    dir_wr_d  = dir_wr_q;
    lba_d     = lba_q;
    blk_cnt_d = blk_cnt_q;
    accept    = (req_rd | req_wr) && !pending_q && !active;
    if (fin_clr) begin
      pending_d = 1'b0;
    end else if (mount && !active) begin
      pending_d = 1'b0;
    end else if (accept) begin
      pending_d = 1'b1;
      dir_wr_d  = req_wr;
      lba_d     = req_lba;
      blk_cnt_d = req_blk_cnt;
    end
  end

  // Request latch registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pending_q <= 1'b0;
      dir_wr_q  <= 1'b0;
      lba_q     <= '0;
      blk_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      dir_wr_q  <= dir_wr_d;
      lba_q     <= lba_d;
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign pending = pending_q;
  assign dir_wr  = dir_wr_q;
  assign lba     = lba_q;
  assign blk_cnt = blk_cnt_q;

endmodule

// File: rtl/ieeedrv_sd_arb.sv
// Round-robin arbiter granting one image channel at a time to the SD host.
// Optional request timeout in ISSUE: define IEEEDRV_SD_ARB_TIMEOUT_EN.
module ieeedrv_sd_arb
  import ieeedrv_pkg::*;
#(
  parameter int unsigned    NCH     = 4,
  parameter int unsigned    BLK_W   = 6,
  parameter logic [TO_W-1:0] TIMEOUT = 24'd8_000_000,
  localparam int unsigned   AW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [NCH-1:0]   img_mounted,
  input  logic [NCH-1:0]   req_rd,
  input  logic [NCH-1:0]   req_wr,
  input  logic [31:0]      req_lba     [NCH],
  input  logic [BLK_W-1:0] req_blk_cnt [NCH],
  output logic [31:0]      sd_lba      [NCH],
  output logic [BLK_W-1:0] sd_blk_cnt  [NCH],
  output logic [NCH-1:0]   sd_rd,
  output logic [NCH-1:0]   sd_wr,
  input  logic [NCH-1:0]   sd_ack,
  output logic [NCH-1:0]   busy,
  output logic [AW-1:0]    act,
  output logic             act_vld,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   err
);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] act_q, act_d;
  logic          act_vld_q, act_vld_d;
  logic [AW-1:0] rr_ptr_q, rr_ptr_d;

  logic [NCH-1:0] pending;
  logic [NCH-1:0] dir_wr;
  logic [NCH-1:0] act_oh;
  logic [NCH-1:0] fin_clr;
  logic [2:0]     pick;
  logic           ack_act;
  logic           to_hit;
  logic           to_err_q;

  // One-hot view of the grant, used for all per-channel outputs and ack selection
  always_comb begin
    act_oh = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      act_oh[i] = act_vld_q && (act_q == AW'(i));
    end
  end

  // Ack from any channel other than the granted one is masked off
  always_comb begin
    ack_act = |(sd_ack & act_oh);
    pick    = rr_pick(8'(pending), 3'(rr_ptr_q), NCH);
    fin_clr = (state_q == ST_FIN) ? act_oh : '0;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_req
    ieeedrv_sd_req #(
      .BLK_W(BLK_W)
    ) u_req (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .req_rd     (req_rd[g]),
      .req_wr     (req_wr[g]),
      .req_lba    (req_lba[g]),
      .req_blk_cnt(req_blk_cnt[g]),
      .mount      (img_mounted[g]),
      .active     (act_oh[g]),
      .fin_clr    (fin_clr[g]),
      .pending    (pending[g]),
      .dir_wr     (dir_wr[g]),
      .lba        (sd_lba[g]),
      .blk_cnt    (sd_blk_cnt[g])
    );
  end

`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_d;

  // Issue-phase watchdog; cleared whenever the FSM is not waiting for ack
  always_comb begin
    to_hit   = (state_q == ST_ISSUE) && !ack_act && (to_cnt_q == TIMEOUT - TO_W'(1));
    to_cnt_d = ((state_q == ST_ISSUE) && !ack_act && !to_hit) ? to_cnt_q + TO_W'(1) : '0;
    to_err_d = to_hit;
  end

  // Watchdog registers; to_err_q marks the FIN cycle as a failure
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end
`else
  assign to_hit   = 1'b0;
  assign to_err_q = 1'b0;
  // TIMEOUT only matters for the watchdog build; referenced here so it stays live.
  if (TIMEOUT == '0) begin : g_to_unused
  end
`endif

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      act_q     <= '0;
      act_vld_q <= 1'b0;
      rr_ptr_q  <= AW'(NCH - 1);
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      act_vld_q <= act_vld_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Next-state logic: grant, request handshake, transfer wait, completion
  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    act_vld_d = act_vld_q;
    rr_ptr_d  = rr_ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          act_d     = AW'(pick);
          act_vld_d = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ack_act) begin
          state_d = ST_XFER;
        end else if (to_hit) begin
          state_d = ST_FIN;
        end
      end
      ST_XFER: begin
        if (!ack_act) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        rr_ptr_d  = act_q;
        act_vld_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: request level in ISSUE only, completion pulse in FIN
  always_comb begin
    sd_rd = '0;
    sd_wr = '0;
    done  = '0;
    err   = '0;
    if (state_q == ST_ISSUE) begin
      sd_rd = act_oh & ~dir_wr;
      sd_wr = act_oh & dir_wr;
    end
    if (state_q == ST_FIN) begin
      if (to_err_q) begin
        err = act_oh;
      end else begin
        done = act_oh;
      end
    end
    busy    = pending | act_oh;
    act     = act_q;
    act_vld = act_vld_q;
  end

endmodule

// File: tb/tb_ieeedrv_sd_arb.sv
// Directed bench for ieeedrv_sd_arb (NCH=4, TIMEOUT=100).
module tb_ieeedrv_sd_arb;

  logic        clk_sys;
  logic        reset;
  logic [3:0]  img_mounted;
  logic [3:0]  req_rd;
  logic [3:0]  req_wr;
  logic [31:0] req_lba     [4];
  logic [5:0]  req_blk_cnt [4];
  logic [31:0] sd_lba      [4];
  logic [5:0]  sd_blk_cnt  [4];
  logic [3:0]  sd_rd;
  logic [3:0]  sd_wr;
  logic [3:0]  sd_ack;
  logic [3:0]  busy;
  logic [1:0]  act;
  logic        act_vld;
  logic [3:0]  done;
  logic [3:0]  err;

  int n_assert = 0;
  int n_fail   = 0;

  ieeedrv_sd_arb #(
    .NCH    (4),
    .BLK_W  (6),
    .TIMEOUT(24'd100)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .img_mounted(img_mounted),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_lba    (req_lba),
    .req_blk_cnt(req_blk_cnt),
    .sd_lba     (sd_lba),
    .sd_blk_cnt (sd_blk_cnt),
    .sd_rd      (sd_rd),
    .sd_wr      (sd_wr),
    .sd_ack     (sd_ack),
    .busy       (busy),
    .act        (act),
    .act_vld    (act_vld),
    .done       (done),
    .err        (err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe on a single channel
  task automatic strobe(input int ch, input bit rd, input bit wr,
                        input logic [31:0] lba, input logic [5:0] cnt);
    req_rd[ch]      = rd;
    req_wr[ch]      = wr;
    req_lba[ch]     = lba;
    req_blk_cnt[ch] = cnt;
    tick();
    req_rd = '0;
    req_wr = '0;
  endtask

  // Wait (bounded) for a request, check it, ack one cycle, check done
  task automatic serve(input string tag, input logic [3:0] exp_rd, input logic [3:0] exp_wr);
    int k;
    k = 0;
    while ((sd_rd | sd_wr) == 4'b0 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_rd"}, 64'(sd_rd), 64'(exp_rd));
    chk({tag, "_wr"}, 64'(sd_wr), 64'(exp_wr));
    sd_ack = exp_rd | exp_wr;
    tick();
    chk({tag, "_drop"}, 64'(sd_rd | sd_wr), 64'h0);
    sd_ack = '0;
    tick();
    chk({tag, "_done"}, 64'(done), 64'(exp_rd | exp_wr));
    tick();
    chk({tag, "_done_end"}, 64'(done), 64'h0);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    img_mounted = '0;
    req_rd      = '0;
    req_wr      = '0;
    sd_ack      = '0;
    for (int i = 0; i < 4; i++) begin
      req_lba[i]     = '0;
      req_blk_cnt[i] = '0;
    end
    repeat (3) tick();
    reset = 1'b0;

    // Reset values
    chk("rst_sd_rd", 64'(sd_rd), 64'h0);
    chk("rst_sd_wr", 64'(sd_wr), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_act", 64'(act), 64'h0);
    chk("rst_act_vld", 64'(act_vld), 64'h0);
    chk("rst_done_err", 64'({done, err}), 64'h0);
    chk("rst_lba1", 64'(sd_lba[1]), 64'h0);

    // Single read on ch1
    strobe(1, 1'b1, 1'b0, 32'd357, 6'd0);
    chk("sr_busy_pend", 64'(busy), 64'h2);
    chk("sr_rd_early", 64'(sd_rd), 64'h0);
    tick();
    chk("sr_rd", 64'(sd_rd), 64'h2);
    chk("sr_lba", 64'(sd_lba[1]), 64'd357);
    chk("sr_cnt", 64'(sd_blk_cnt[1]), 64'd0);
    chk("sr_act", 64'({act_vld, act}), 64'h5);
    tick();
    chk("sr_rd_hold", 64'(sd_rd), 64'h2);
    sd_ack = 4'b0001;
    tick();
    chk("sr_wrong_ack", 64'(sd_rd), 64'h2);
    sd_ack = 4'b0010;
    tick();
    chk("sr_rd_drop", 64'(sd_rd), 64'h0);
    tick();
    tick();
    sd_ack = '0;
    chk("sr_no_done_xfer", 64'(done), 64'h0);
    tick();
    chk("sr_done", 64'(done), 64'h2);
    tick();
    chk("sr_done_end", 64'(done), 64'h0);
    chk("sr_idle", 64'({busy, act_vld}), 64'h0);

    // Set rr_ptr to 0 via a ch0 transfer, then fairness among ch0/2/3
    strobe(0, 1'b1, 1'b0, 32'h100, 6'd1);
    serve("rr_setup", 4'b0001, 4'b0000);
    req_rd         = 4'b1101;
    req_lba[0]     = 32'h1000_0000;
    req_lba[2]     = 32'h2000_0002;
    req_lba[3]     = 32'h3000_0003;
    req_blk_cnt[2] = 6'd63;
    tick();
    req_rd = '0;
    chk("fair_busy", 64'(busy), 64'hD);
    serve("fair_g2", 4'b0100, 4'b0000);
    chk("fair_lba2", 64'(sd_lba[2]), 64'h2000_0002);
    chk("fair_cnt2", 64'(sd_blk_cnt[2]), 64'd63);
    serve("fair_g3", 4'b1000, 4'b0000);
    serve("fair_g0", 4'b0001, 4'b0000);

    // Collision: write wins, second strobe while busy ignored
    strobe(0, 1'b1, 1'b1, 32'h0000_1000, 6'd2);
    tick();
    chk("col_wr", 64'(sd_wr), 64'h1);
    chk("col_rd", 64'(sd_rd), 64'h0);
    strobe(0, 1'b1, 1'b0, 32'h0000_2222, 6'd7);
    chk("col_lba_kept", 64'(sd_lba[0]), 64'h0000_1000);
    chk("col_cnt_kept", 64'(sd_blk_cnt[0]), 64'd2);
    serve("col", 4'b0000, 4'b0001);

    // Cancel pending ch3 while ch1 active; mount on ch1 must not abort it
    strobe(1, 1'b1, 1'b0, 32'h11, 6'd0);
    tick();
    chk("can_rd1", 64'(sd_rd), 64'h2);
    strobe(3, 1'b1, 1'b0, 32'h33, 6'd0);
    chk("can_busy", 64'(busy), 64'hA);
    img_mounted = 4'b1010;
    tick();
    img_mounted = '0;
    chk("can_busy_clr", 64'(busy), 64'h2);
    serve("can_ch1", 4'b0010, 4'b0000);
    repeat (3) tick();
    chk("can_no_grant", 64'({sd_rd, sd_wr}), 64'h0);
    chk("can_idle_busy", 64'(busy), 64'h0);

    // Reset during XFER on ch2
    strobe(2, 1'b0, 1'b1, 32'hCAFE_0002, 6'd5);
    tick();
    chk("rx_wr", 64'(sd_wr), 64'h4);
    chk("rx_cnt", 64'(sd_blk_cnt[2]), 64'd5);
    sd_ack = 4'b0100;
    tick();
    chk("rx_xfer", 64'(sd_wr), 64'h0);
    reset = 1'b1;
    tick();
    chk("rx_rdwr", 64'({sd_rd, sd_wr}), 64'h0);
    chk("rx_busy", 64'(busy), 64'h0);
    chk("rx_act", 64'({act_vld, act}), 64'h0);
    chk("rx_done_err", 64'({done, err}), 64'h0);
    chk("rx_lba", 64'(sd_lba[2]), 64'h0);
    chk("rx_cnt0", 64'(sd_blk_cnt[2]), 64'h0);
    reset  = 1'b0;
    sd_ack = '0;
    tick();
    chk("rx_no_done", 64'(done), 64'h0);

    // Reset during ISSUE on ch1
    strobe(1, 1'b1, 1'b0, 32'h77, 6'd0);
    tick();
    chk("ri_rd", 64'(sd_rd), 64'h2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ri_drop", 64'({sd_rd, busy, done}), 64'h0);

    // Timeout behaviour on ch0 (rr_ptr back at 3 after reset)
    strobe(0, 1'b1, 1'b0, 32'h99, 6'd0);
    tick();
    chk("to_rd", 64'(sd_rd), 64'h1);
`ifdef IEEEDRV_SD_ARB_TIMEOUT_EN
    n = 0;
    while (sd_rd != 4'b0 && n < 300) begin
      tick();
      n++;
    end
    chk("to_cycles", 64'(n), 64'd100);
    chk("to_err", 64'(err), 64'h1);
    chk("to_no_done", 64'(done), 64'h0);
    tick();
    chk("to_err_end", 64'(err), 64'h0);
    chk("to_busy", 64'(busy), 64'h0);
`else
    n = 0;
    repeat (200) begin
      tick();
      n++;
    end
    chk("hold_cycles", 64'(n), 64'd200);
    chk("hold_rd", 64'(sd_rd), 64'h1);
    chk("hold_busy", 64'(busy), 64'h1);
    chk("hold_err", 64'(err), 64'h0);
    serve("hold_fin", 4'b0001, 4'b0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ieeedrv_sd_arb.md
IEEEDRV_SD_ARB -- requirements
Module: ieeedrv_sd_arb

Interface
REQ-001 SHALL have parameter NCH, default 4: number of image channels (drives × subdrives), 1..8.
REQ-002 SHALL have parameter BLK_W, default 6: width of block-count fields.
REQ-003 SHALL have parameter TIMEOUT, default 24'd8_000_000: clk_sys cycles allowed from request issue to sd_ack.
REQ-004 clk_sys  in  1  system clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 img_mounted  in  NCH  per-channel mount strobe; cancels that channel's pending request.
REQ-007 req_rd / req_wr  in  NCH each  one-cycle request strobes per channel.
REQ-008 req_lba[NCH]  in  32 each  start LBA, sampled with the strobe.
REQ-009 req_blk_cnt[NCH]  in  BLK_W each  blocks minus one, sampled with the strobe.
REQ-010 sd_lba[NCH] / sd_blk_cnt[NCH]  out  32 / BLK_W each  captured request parameters.
REQ-011 sd_rd / sd_wr  out  NCH each  request level to the host, one-hot or zero.
REQ-012 sd_ack  in  NCH  host acknowledge, high for the duration of the transfer.
REQ-013 busy  out  NCH  channel pending or active.
REQ-014 act  out  $clog2(NCH) (min 1)  granted channel index; act_vld out 1 grant valid.
REQ-015 done / err  out  NCH each  one-cycle completion and failure pulses.

Function
REQ-016 SHALL latch a strobe into a per-channel pending bit with rd/wr direction, LBA, and count, only if that channel is neither pending nor active; otherwise SHALL ignore it.
REQ-017 If req_rd and req_wr arrive together, SHALL take the write.
REQ-018 FSM states SHALL be IDLE, ISSUE, XFER, FIN.
REQ-019 IDLE: if any channel is pending, SHALL grant the first pending channel at or after rr_ptr+1 (mod NCH), set act and act_vld, and go to ISSUE on the next cycle.
REQ-020 ISSUE: SHALL assert sd_rd[act] or sd_wr[act] and hold it until sd_ack[act] is sampled high, then drop it and go to XFER.
REQ-021 XFER: SHALL wait for sd_ack[act] low, then go to FIN.
REQ-022 FIN: SHALL pulse done[act] for exactly 1 cycle, clear pending, set rr_ptr to act, clear act_vld, and return to IDLE.
REQ-023 Minimum turnaround SHALL be request strobe to sd_rd/sd_wr high in 2 cycles, and ack-low to done in 1 cycle.
REQ-024 sd_ack on a channel other than act SHALL be ignored.
REQ-025 img_mounted[i] on a pending, not-yet-granted channel SHALL clear its pending bit with no done and no err.
REQ-026 img_mounted[i] on the active channel SHALL NOT abort the transfer.
REQ-027 At most one bit of sd_rd|sd_wr SHALL be high at any time.
REQ-028 busy[i] SHALL equal pending[i] | (act_vld & act==i).

Reset
REQ-029 On reset, SHALL set state IDLE; clear pending, sd_rd, sd_wr, done, err, and act_vld; set act=0, rr_ptr=NCH-1, and the timeout counter to 0.
REQ-030 Reset mid-ISSUE or mid-XFER SHALL drop sd_rd/sd_wr on the next edge with no done pulse.
REQ-031 sd_lba and sd_blk_cnt SHALL reset to 0.

Configuration
REQ-032 With IEEEDRV_SD_ARB_TIMEOUT_EN defined, a 24-bit counter SHALL run in ISSUE.
REQ-033 With IEEEDRV_SD_ARB_TIMEOUT_EN defined, if TIMEOUT cycles elapse without sd_ack[act], SHALL drop the request, pulse err[act] (no done), and go to FIN-equivalent cleanup.
REQ-034 With IEEEDRV_SD_ARB_TIMEOUT_EN defined, the counter SHALL NOT run in XFER.
REQ-035 Without IEEEDRV_SD_ARB_TIMEOUT_EN, ISSUE SHALL wait indefinitely, err SHALL be tied to 0, and no counter SHALL be synthesised.

Structure
REQ-036 State encoding enum and the round-robin helper function SHALL go in package ieeedrv_pkg.
REQ-037 The per-channel request latch (pending, dir, lba, cnt) SHALL be sub-module ieeedrv_sd_req, instantiated NCH times by generate.

Verification
REQ-038 Single read: req_rd[1] with lba=357, cnt=0 -> sd_lba[1]=357, sd_rd=4'b0010 two cycles later; sd_ack[1] high 3 cycles then low -> done[1] one cycle after ack falls.
REQ-039 Fairness: ch0, ch2, and ch3 all pending with rr_ptr=0 -> grant order 2, 3, 0, each done before the next sd_rd rises.
REQ-040 Collision: req_rd[0] and req_wr[0] in the same cycle -> sd_wr[0] asserted, sd_rd stays 0; a second req_rd[0] while busy[0] -> ignored, sd_lba[0] unchanged.
REQ-041 Cancel: ch3 pending while ch1 active, pulse img_mounted[3] -> busy[3]=0, ch3 never granted, and ch1 completes with done[1].
REQ-042 Reset in XFER: assert reset while sd_ack[2]=1 -> next cycle all outputs at reset values, no done[2].
REQ-043 Timeout (macro on, TIMEOUT=100): no sd_ack -> sd_rd drops, err[act] pulses at cycle 100 of ISSUE, busy clears; macro off -> request held after 200 cycles.
